mem_access_arbiter: RTL and testbench

Arbitrates up to `NUM_CLIENTS` requesters onto one single-port, one-cycle-read-latency SRAM bank, directly upstream of the bank model. Each cycle it grants at most one read or write, and drives the bank's write/read/chip-enable signals so that a read and a write never coincide. It returns read data to the originating client with a registered response valid.

---
 rtl/mem_access_arbiter_pkg.sv | 13 +
 rtl/mem_arb_priority_pick.sv | 31 +++
 rtl/mem_access_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and default widths for the single-port SRAM access arbiter.
package mem_access_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mem_arb_state_t;

    localparam int MEM_ARB_ADDR_W      = 10;
    localparam int MEM_ARB_DATA_W      = 16;
    localparam int MEM_ARB_NUM_CLIENTS = 4;

endpackage

// File: rtl/mem_arb_priority_pick.sv
// Combinational one-hot picker: first valid client found scanning upward
// from start_i, wrapping at N-1.
module mem_arb_priority_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [N-1:0]     grant_o
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // rotating scan; the first hit wins and later hits are ignored
    always_comb begin
        grant_o = '0;
        found_s = 1'b0;
        idx_s   = start_i;
        for (int i = 0; i < N; i++) begin
            if (!found_s && valid_i[idx_s]) begin
                grant_o[idx_s] = 1'b1;
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
            idx_s = (idx_s == PTR_W'(N - 1)) ? '0 : idx_s + PTR_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates NUM_CLIENTS requesters onto one single-port SRAM bank with lock support.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin priority; otherwise lowest index wins.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = MEM_ARB_NUM_CLIENTS,
    parameter int ADDR_W      = MEM_ARB_ADDR_W,
    parameter int DATA_W      = MEM_ARB_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        req_valid,
    input  logic [NUM_CLIENTS-1:0]        req_write,
    input  logic [NUM_CLIENTS-1:0]        req_lock,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]        req_ready,
    output logic [NUM_CLIENTS-1:0]        rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          mem_write_en,
    output logic                          mem_read_en,
    output logic                          mem_chip_en,
    output logic [ADDR_W-1:0]             mem_write_addr,
    output logic [ADDR_W-1:0]             mem_read_addr,
    output logic [DATA_W-1:0]             mem_write_data,
    input  logic [DATA_W-1:0]             mem_read_data
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    mem_arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [NUM_CLIENTS-1:0]   tag_q, tag_d;

    logic [IDX_W-1:0]         pick_start_s;
    logic [NUM_CLIENTS-1:0]   pick_grant_s;
    logic [IDX_W-1:0]         pick_idx_s;
    logic [NUM_CLIENTS-1:0]   grant_raw_s;
    logic [NUM_CLIENTS-1:0]   grant_s;
    logic [IDX_W-1:0]         sel_idx_s;
    logic                     any_grant_s;
    logic                     is_write_s;
    logic [ADDR_W-1:0]        addr_a [NUM_CLIENTS];
    logic [DATA_W-1:0]        wdata_a [NUM_CLIENTS];

    mem_arb_priority_pick #(
        .N     (NUM_CLIENTS),
        .PTR_W (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .start_i (pick_start_s),
        .grant_o (pick_grant_s)
    );

    // encode the picker's one-hot result as an index
    always_comb begin
        pick_idx_s = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            pick_idx_s = pick_grant_s[i] ? IDX_W'(i) : pick_idx_s;
        end
    end

    // lock FSM: in LOCKED only the recorded owner can be served
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        grant_raw_s = '0;
        sel_idx_s   = pick_idx_s;
        case (state_q)
            IDLE: begin
                grant_raw_s = pick_grant_s;
                if ((|pick_grant_s) && req_lock[pick_idx_s]) begin
                    state_d = LOCKED;
                    owner_d = pick_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                sel_idx_s = owner_q;
                if (req_valid[owner_q]) begin
                    grant_raw_s[owner_q] = 1'b1;
                    state_d = req_lock[owner_q] ? LOCKED : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // unpack the flattened per-client buses
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
        end
    end

    // bank drive; nothing is granted while reset is held
    always_comb begin
        grant_s        = rst_n ? grant_raw_s : '0;
        any_grant_s    = |grant_s;
        is_write_s     = req_write[sel_idx_s];
        req_ready      = grant_s;
        mem_chip_en    = any_grant_s;
        mem_write_en   = any_grant_s & is_write_s;
        mem_read_en    = any_grant_s & ~is_write_s;
        mem_write_addr = mem_write_en ? addr_a[sel_idx_s]  : '0;
        mem_write_data = mem_write_en ? wdata_a[sel_idx_s] : '0;
        mem_read_addr  = mem_read_en  ? addr_a[sel_idx_s]  : '0;
        tag_d          = mem_read_en  ? grant_s : '0;
    end

    // state, lock owner and read-response tag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            tag_q   <= tag_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // advance past the client just served, but only for beats won in IDLE
    always_comb begin
        if ((state_q == IDLE) && any_grant_s) begin
            ptr_d = (pick_idx_s == IDX_W'(NUM_CLIENTS - 1)) ? '0 : pick_idx_s + IDX_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pick_start_s = ptr_q;
`else
    assign pick_start_s = '0;
`endif

    // reset kills a pending response in the same cycle it is asserted
    assign rsp_valid = rst_n ? tag_q : '0;
    assign rsp_data  = (rst_n && (|tag_q)) ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed + random bench for mem_access_arbiter with a transaction-level reference
// model and a behavioural SRAM bank. Honours MEM_ARB_ROUND_ROBIN_EN like the design.
module tb_mem_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_write_en, mem_read_en, mem_chip_en;
    logic [AW-1:0]   mem_write_addr, mem_read_addr;
    logic [DW-1:0]   mem_write_data;
    logic [DW-1:0]   mem_read_data = '0;

    always #5 clk = ~clk;

    mem_access_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_chip_en(mem_chip_en),
        .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Behavioural bank: one-cycle registered read
    logic [DW-1:0] bank_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_write_en) bank_mem[mem_write_addr] <= mem_write_data;
        if (mem_read_en)  mem_read_data <= bank_mem[mem_read_addr];
    end

    // Reference model state
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    bit            m_locked;
    int            m_owner, m_ptr, m_pend;
    logic [DW-1:0] m_pend_data;

    int n_vec = 0, n_fail = 0;
    logic [N-1:0]  s_ready, s_rsp_valid;
    logic [DW-1:0] s_rsp_data;
    logic          s_we;
    logic [63:0]   s_all;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int c);
        return req_addr[c*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int c);
        return req_wdata[c*DW +: DW];
    endfunction

    // Who must be granted this cycle, -1 for nobody
    function automatic int model_grant();
        if (!rst_n) return -1;
        if (m_locked) return req_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (!rst_n) begin
            m_locked = 1'b0; m_ptr = 0; m_pend = -1;
        end else begin
            m_pend = -1;
            if (g >= 0) begin
                if (req_write[g]) model_mem[addr_of(g)] = wdata_of(g);
                else begin m_pend = g; m_pend_data = model_mem[addr_of(g)]; end
                if (!m_locked) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    m_ptr = (g + 1) % N;
`endif
                    if (req_lock[g]) begin m_locked = 1'b1; m_owner = g; end
                end else if (!req_lock[g]) begin
                    m_locked = 1'b0;
                end
            end else if (m_locked && !req_valid[m_owner]) begin
                m_locked = 1'b0;
            end
        end
    endtask

    // One clock: predict, compare at the falling edge, advance the model at the rising edge
    task automatic cycle();
        int g;
        logic [N-1:0] e_rdy, e_rv;
        logic e_we, e_re, e_ce;
        logic [AW-1:0] e_wa, e_ra;
        logic [DW-1:0] e_wd, e_rd;
        g = model_grant();
        e_rdy = '0; e_we = 1'b0; e_re = 1'b0; e_ce = 1'b0;
        e_wa = '0; e_ra = '0; e_wd = '0;
        if (g >= 0) begin
            e_rdy = 4'b0001 << g;
            e_ce  = 1'b1;
            if (req_write[g]) begin e_we = 1'b1; e_wa = addr_of(g); e_wd = wdata_of(g); end
            else begin e_re = 1'b1; e_ra = addr_of(g); end
        end
        e_rv = (rst_n && m_pend >= 0) ? (4'b0001 << m_pend) : 4'b0000;
        e_rd = (rst_n && m_pend >= 0) ? m_pend_data : 16'h0000;
        @(negedge clk);
        s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_data = rsp_data; s_we = mem_write_en;
        s_all = {1'b0, req_ready, rsp_valid, rsp_data, mem_write_en, mem_read_en, mem_chip_en,
                 mem_write_addr, mem_read_addr, mem_write_data};
        chk("req_ready", req_ready, e_rdy);
        chk("mem_chip_en", mem_chip_en, e_ce);
        chk("mem_write_en", mem_write_en, e_we);
        chk("mem_read_en", mem_read_en, e_re);
        chk("mem_write_addr", mem_write_addr, e_wa);
        chk("mem_read_addr", mem_read_addr, e_ra);
        chk("mem_write_data", mem_write_data, e_wd);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("we_and_re", mem_write_en & mem_read_en, 1'b0);
        chk("en_without_ce", (mem_write_en | mem_read_en) & ~mem_chip_en, 1'b0);
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic clr();
        req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic rq(input int c, input bit wr, input bit lk,
                      input logic [AW-1:0] ad, input logic [DW-1:0] dt);
        req_valid[c] = 1'b1; req_write[c] = wr; req_lock[c] = lk;
        req_addr[c*AW +: AW] = ad; req_wdata[c*DW +: DW] = dt;
    endtask

    logic [N-1:0] exp_seq [5];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin bank_mem[i] = '0; model_mem[i] = '0; end
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_pend = -1; m_pend_data = '0;
        clr();
        rst_n = 1'b0;
        @(posedge clk); #1;

        // Reset: requests present but nothing may be granted
        req_valid = 4'hF;
        cycle();
        chk("reset_ready", s_ready, 4'b0000);
        chk("reset_all_outputs", s_all, 64'd0);
        clr(); cycle();
        rst_n = 1'b1;

        // Single write then read of the same word
        clr(); rq(0, 1'b1, 1'b0, 10'h005, 16'h1234); cycle();
        chk("wr_ready", s_ready, 4'b0001);
        chk("wr_we", s_we, 1'b1);
        clr(); rq(0, 1'b0, 1'b0, 10'h005, 16'h0000); cycle();
        chk("rd_ready", s_ready, 4'b0001);
        clr(); cycle();
        chk("rd_rsp_valid", s_rsp_valid, 4'b0001);
        chk("rd_rsp_data", s_rsp_data, 16'h1234);

        // Contention between clients 1 and 3
        clr(); rq(1, 1'b1, 1'b0, 10'h010, 16'hAAAA); cycle();
        clr(); rq(3, 1'b1, 1'b0, 10'h020, 16'hBBBB); cycle();
        clr(); rq(1, 1'b0, 1'b0, 10'h010, 16'h0000); rq(3, 1'b0, 1'b0, 10'h020, 16'h0000); cycle();
        chk("cont_first", s_ready, 4'b0010);
        clr(); rq(3, 1'b0, 1'b0, 10'h020, 16'h0000); cycle();
        chk("cont_second", s_ready, 4'b1000);
        chk("cont_rsp1_valid", s_rsp_valid, 4'b0010);
        chk("cont_rsp1_data", s_rsp_data, 16'hAAAA);
        clr(); cycle();
        chk("cont_rsp3_valid", s_rsp_valid, 4'b1000);
        chk("cont_rsp3_data", s_rsp_data, 16'hBBBB);

        // All four clients request continuously
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
`else
        for (int i = 0; i < 5; i++) exp_seq[i] = 4'b0001;
`endif
        for (int i = 0; i < 5; i++) begin
            clr();
            for (int c = 0; c < N; c++) rq(c, 1'b0, 1'b0, 10'h005, 16'h0000);
            cycle();
            chk("all_req_order", s_ready, exp_seq[i]);
        end
        clr(); cycle();

        // Lock: client 2 holds the bank for three beats while client 0 waits
        clr(); rq(2, 1'b1, 1'b1, 10'h030, 16'hC001); cycle();
        chk("lock_beat1", s_ready, 4'b0100);
        clr(); rq(2, 1'b1, 1'b1, 10'h031, 16'hC002); rq(0, 1'b0, 1'b0, 10'h030, 16'h0000); cycle();
        chk("lock_beat2", s_ready, 4'b0100);
        clr(); rq(2, 1'b1, 1'b0, 10'h032, 16'hC003); rq(0, 1'b0, 1'b0, 10'h030, 16'h0000); cycle();
        chk("lock_beat3", s_ready, 4'b0100);
        clr(); rq(0, 1'b0, 1'b0, 10'h030, 16'h0000); cycle();
        chk("lock_release", s_ready, 4'b0001);
        clr(); cycle();
        chk("lock_rd_data", s_rsp_data, 16'hC001);

        // Lock owner drops valid: one dead cycle, then others may win
        clr(); rq(1, 1'b0, 1'b1, 10'h031, 16'h0000); cycle();
        chk("drop_grant", s_ready, 4'b0010);
        clr(); rq(0, 1'b0, 1'b0, 10'h032, 16'h0000); cycle();
        chk("drop_blocked", s_ready, 4'b0000);
        chk("drop_rsp_data", s_rsp_data, 16'hC002);
        clr(); rq(0, 1'b0, 1'b0, 10'h032, 16'h0000); cycle();
        chk("drop_after", s_ready, 4'b0001);
        clr(); cycle();
        chk("drop_after_data", s_rsp_data, 16'hC003);

        // Reset in the cycle after a read grant
        clr(); rq(2, 1'b0, 1'b0, 10'h030, 16'h0000); cycle();
        chk("rstmid_grant", s_ready, 4'b0100);
        clr(); rq(0, 1'b1, 1'b0, 10'h005, 16'hFFFF); rst_n = 1'b0; cycle();
        chk("rstmid_rsp_valid", s_rsp_valid, 4'b0000);
        chk("rstmid_all_outputs", s_all, 64'd0);
        rst_n = 1'b1; clr(); cycle();
        chk("rstmid_after", s_rsp_valid, 4'b0000);
        clr(); rq(0, 1'b0, 1'b0, 10'h005, 16'h0000); cycle();
        clr(); cycle();
        chk("rstmid_no_write", s_rsp_data, 16'h1234);

        // Random traffic, model-checked every cycle
        for (int n = 0; n < 10000; n++) begin
            clr();
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) != 0)
                    rq(c, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                       10'($urandom_range(0, 15)), 16'($urandom));
            end
            rst_n = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
